// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - cache line refill controller (optional REFILL_CRITICAL_WORD_FIRST_EN)
module cache_refill_ctrl #(
  parameter int ADDR_W = 64,
  parameter int BEATS  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  miss_req_i,
  input  logic [ADDR_W-1:0]     miss_addr_i,
  output logic                  miss_ready_o,
  output logic                  busreq_o,
  input  logic                  busgrant_i,
  output logic                  busidle_o,
  output logic                  bus_reqcyc_o,
  output logic [ADDR_W-1:0]     bus_req_o,
  input  logic                  bus_reqack_i,
  input  logic                  bus_respcyc_i,
  input  logic [63:0]           bus_resp_i,
  output logic                  bus_respack_o,
  output logic                  fill_valid_o,
  output logic [ADDR_W-1:0]     fill_addr_o,
  output logic [64*BEATS-1:0]   fill_data_o
);

  localparam int CNT_W    = $clog2(BEATS);
  localparam int LINE_OFF = CNT_W + 3;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(7);

  typedef enum logic [2:0] {IDLE, ARB, REQ, RESP, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [64*BEATS-1:0]   buf_q, buf_d;
  logic [64*BEATS-1:0]   fill_data_q, fill_data_d;
  logic [ADDR_W-1:0]     fill_addr_q, fill_addr_d;
  logic                  accept, beat_ack, last_beat;
  logic [CNT_W-1:0]      word_idx;
  logic [ADDR_W-1:0]     line_addr;

  assign accept    = miss_req_i & miss_ready_o;
  assign beat_ack  = bus_respack_o;
  assign last_beat = (beat_q == CNT_W'(BEATS - 1));
  assign line_addr = addr_q & LINE_MASK;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  // Memory returns the missing word first and wraps around the line.
  assign word_idx  = addr_q[3 +: CNT_W] + beat_q;
  assign bus_req_o = addr_q & WORD_MASK;
`else
  assign word_idx  = beat_q;
  assign bus_req_o = line_addr;
`endif

  assign fill_addr_o = fill_addr_q;
  assign fill_data_o = fill_data_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state: grant is only looked at in ARB, so a later grant drop is harmless
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_req_i)                  state_d = ARB;
      ARB:     if (busgrant_i)                  state_d = REQ;
      REQ:     if (bus_reqack_i)                state_d = RESP;
      RESP:    if (bus_respcyc_i && last_beat)  state_d = DONE;
      DONE:                                     state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; the bus is held from ARB through DONE
  always_comb begin
    miss_ready_o  = 1'b0;
    busreq_o      = 1'b0;
    busidle_o     = 1'b0;
    bus_reqcyc_o  = 1'b0;
    bus_respack_o = 1'b0;
    fill_valid_o  = 1'b0;
    case (state_q)
      IDLE: begin miss_ready_o = 1'b1; busidle_o = 1'b1; end
      ARB:  begin busreq_o = 1'b1; busidle_o = 1'b1; end
      REQ:  begin busreq_o = 1'b1; bus_reqcyc_o = 1'b1; end
      RESP: begin busreq_o = 1'b1; bus_respack_o = bus_respcyc_i; end
      DONE: begin busreq_o = 1'b1; fill_valid_o = 1'b1; end
      default: ;
    endcase
  end

  // Beats assemble in a private buffer so the published line stays stable until the next DONE
  always_comb begin
    addr_d      = addr_q;
    beat_d      = beat_q;
    buf_d       = buf_q;
    fill_data_d = fill_data_q;
    fill_addr_d = fill_addr_q;
    if (accept) begin
      addr_d = miss_addr_i;
      beat_d = '0;
    end
    if (beat_ack) begin
      buf_d[{word_idx, 6'b0} +: 64] = bus_resp_i;
      beat_d = beat_q + 1'b1;
      if (last_beat) begin
        fill_data_d = buf_d;
        fill_addr_d = line_addr;
      end
    end
  end

  // Datapath registers; reset discards any partial line
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      addr_q      <= '0;
      beat_q      <= '0;
      buf_q       <= '0;
      fill_data_q <= '0;
      fill_addr_q <= '0;
    end else begin
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      buf_q       <= buf_d;
      fill_data_q <= fill_data_d;
      fill_addr_q <= fill_addr_d;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - randomized self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

  localparam int ADDR_W = 64;
  localparam int BEATS  = 8;
  localparam int LW     = 64 * BEATS;
  localparam int LINE_B = 8 * BEATS;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              busreq;
  logic              busgrant;
  logic              busidle;
  logic              bus_reqcyc;
  logic [ADDR_W-1:0] bus_req;
  logic              bus_reqack;
  logic              bus_respcyc;
  logic [63:0]       bus_resp;
  logic              bus_respack;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [LW-1:0]     fill_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [LW-1:0] held_data;
  logic [63:0]   held_addr;

  cache_refill_ctrl #(.ADDR_W(ADDR_W), .BEATS(BEATS)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .miss_req_i(miss_req), .miss_addr_i(miss_addr), .miss_ready_o(miss_ready),
    .busreq_o(busreq), .busgrant_i(busgrant), .busidle_o(busidle),
    .bus_reqcyc_o(bus_reqcyc), .bus_req_o(bus_req), .bus_reqack_i(bus_reqack),
    .bus_respcyc_i(bus_respcyc), .bus_resp_i(bus_resp), .bus_respack_o(bus_respack),
    .fill_valid_o(fill_valid), .fill_addr_o(fill_addr), .fill_data_o(fill_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_bus_req(input logic [63:0] a);
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    return a - (a % 8);
`else
    return a - (a % LINE_B);
`endif
  endfunction

  function automatic int exp_word(input logic [63:0] a, input int k);
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    return (int'((a / 8) % BEATS) + k) % BEATS;
`else
    return k;
`endif
  endfunction

  // gap_mode: 0 back-to-back, 1 gap before every beat, 2 random gaps; rst_after: abort after that many beats (-1 none)
  task automatic refill(input logic [63:0] addr, input int gdly, input int adly, input int gap_mode,
                        input int rst_after, input bit intrude, input bit stray, input bit count_data);
    logic [LW-1:0] line;
    logic [63:0]   beat;
    int            start_cyc;
    bit            gap;
    line = held_data;
    if (stray) begin
      bus_respcyc = 1'b1; bus_resp = {$urandom, $urandom};
      #1;
      check("idle_stray_ack", bus_respack, 0);
      tick();
      bus_respcyc = 1'b0;
    end
    miss_req = 1'b1; miss_addr = addr;
    #1;
    check("idle_ready", miss_ready, 1);
    check("idle_busreq", busreq, 0);
    check("idle_busidle", busidle, 1);
    check("idle_reqcyc", bus_reqcyc, 0);
    check("idle_fill_valid", fill_valid, 0);
    check("held_data", fill_data, held_data);
    check("held_addr", fill_addr, held_addr);
    start_cyc = cyc;
    tick();
    miss_req = 1'b0; miss_addr = {$urandom, $urandom};
    for (int i = 0; i <= gdly; i++) begin
      busgrant = (i == gdly);
      miss_req = $urandom_range(0, 1);
      #1;
      check("arb_busreq", busreq, 1);
      check("arb_busidle", busidle, 1);
      check("arb_reqcyc", bus_reqcyc, 0);
      check("arb_ready", miss_ready, 0);
      tick();
    end
    busgrant = $urandom_range(0, 1);
    miss_req = 1'b0;
    for (int i = 0; i <= adly; i++) begin
      bus_reqack = (i == adly);
      #1;
      check("req_reqcyc", bus_reqcyc, 1);
      check("req_addr", bus_req, exp_bus_req(addr));
      check("req_busidle", busidle, 0);
      check("req_busreq", busreq, 1);
      tick();
    end
    bus_reqack = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 2) == 0);
      if (intrude) begin miss_req = 1'b1; miss_addr = {$urandom, $urandom}; end
      if (gap) begin
        bus_respcyc = 1'b0;
        #1;
        check("gap_ack", bus_respack, 0);
        check("gap_ready", miss_ready, 0);
        tick();
      end
      beat = count_data ? 64'(k) : {$urandom, $urandom};
      bus_respcyc = 1'b1; bus_resp = beat;
      #1;
      check("beat_ack", bus_respack, 1);
      check("beat_ready", miss_ready, 0);
      check("beat_busreq", busreq, 1);
      check("beat_busidle", busidle, 0);
      check("beat_fill_valid", fill_valid, 0);
      line[exp_word(addr, k)*64 +: 64] = beat;
      tick();
      if (rst_after == k + 1) begin
        bus_respcyc = 1'b0; miss_req = 1'b0; reset_n = 1'b0;
        tick();
        check("rst_ready", miss_ready, 1);
        check("rst_busreq", busreq, 0);
        check("rst_busidle", busidle, 1);
        check("rst_fill_valid", fill_valid, 0);
        check("rst_fill_data", fill_data, 0);
        check("rst_fill_addr", fill_addr, 0);
        held_data = '0; held_addr = '0;
        reset_n = 1'b1;
        #1;
        check("rst_after_fill_valid", fill_valid, 0);
        return;
      end
    end
    miss_req = 1'b0;
    bus_respcyc = 1'b1; bus_resp = {$urandom, $urandom};
    #1;
    check("done_fill_valid", fill_valid, 1);
    check("done_stray_ack", bus_respack, 0);
    check("done_busreq", busreq, 1);
    check("done_busidle", busidle, 0);
    check("done_fill_addr", fill_addr, addr - (addr % LINE_B));
    check("done_fill_data", fill_data, line);
    if (gdly == 0 && adly == 0 && gap_mode == 0)
      check("latency", cyc - start_cyc, 11);
    held_data = line; held_addr = addr - (addr % LINE_B);
    tick();
    bus_respcyc = 1'b0;
    #1;
    check("post_fill_valid", fill_valid, 0);
    check("post_ready", miss_ready, 1);
    check("post_held_data", fill_data, held_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; miss_req = 1'b0; miss_addr = '0; busgrant = 1'b0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
    held_data = '0; held_addr = '0;
    tick(); tick();
    check("reset_ready", miss_ready, 1);
    check("reset_busreq", busreq, 0);
    check("reset_busidle", busidle, 1);
    check("reset_reqcyc", bus_reqcyc, 0);
    check("reset_bus_req", bus_req, 0);
    check("reset_fill_valid", fill_valid, 0);
    check("reset_fill_addr", fill_addr, 0);
    check("reset_fill_data", fill_data, 0);
    tick();
    reset_n = 1'b1;
    refill(64'h1000, 0, 0, 0, -1, 1'b0, 1'b0, 1'b1);
    refill(64'h2040, 5, 2, 0, -1, 1'b0, 1'b0, 1'b0);
    refill(64'h3000, 0, 0, 1, -1, 1'b0, 1'b0, 1'b0);
    refill(64'h4000, 1, 1, 0, 4, 1'b0, 1'b0, 1'b0);
    refill(64'h5000, 0, 0, 0, -1, 1'b0, 1'b0, 1'b0);
    refill(64'h1028, 0, 0, 0, -1, 1'b0, 1'b0, 1'b1);
    refill(64'h6018, 2, 1, 2, -1, 1'b1, 1'b1, 1'b0);
    for (int t = 0; t < 25; t++) begin
      refill({$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 3),
             $urandom_range(0, 2), ($urandom_range(0, 5) == 0) ? $urandom_range(1, BEATS - 1) : -1,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter ADDR_W, 64, address width in bits SHALL be supported.
REQ-002 Parameter BEATS, 8, 64-bit beats per cache line (line = 64 B) SHALL be supported; BEATS is a power of two.
REQ-003 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 miss_req  in  1  cache requests a line refill; miss_addr  in  ADDR_W  missing byte address.
REQ-006 miss_ready  out  1  high when a new miss is accepted (miss_req & miss_ready = accept).
REQ-007 busreq  out  1  bus request to arbiter; busgrant  in  1  arbiter grant.
REQ-008 busidle  out  1  high when this block is not driving the memory bus.
REQ-009 bus_reqcyc  out  1  read request valid; bus_req  out  ADDR_W  request address; bus_reqack  in  1  request accepted.
REQ-010 bus_respcyc  in  1  response beat valid; bus_resp  in  64  beat data; bus_respack  out  1  beat consumed.
REQ-011 fill_valid  out  1  one-cycle line-complete pulse; fill_addr  out  ADDR_W  line-aligned address; fill_data  out  64*BEATS  assembled line, word i at bits [64i+63:64i].

Function
REQ-012 FSM states SHALL be IDLE, ARB, REQ, RESP, DONE.
REQ-013 IDLE: miss_ready=1; on miss_req SHALL capture miss_addr and go to ARB.
REQ-014 ARB: busreq=1; on busgrant=1 SHALL go to REQ; otherwise remain.
REQ-015 busreq SHALL stay high from ARB through DONE inclusive; busgrant deassertion after ARB SHALL be ignored.
REQ-016 busidle SHALL be 0 in REQ, RESP, DONE and 1 in IDLE, ARB.
REQ-017 REQ: bus_reqcyc=1, bus_req held stable until bus_reqack=1, then go to RESP.
REQ-018 RESP: bus_respack SHALL equal bus_respcyc (combinational); each acked beat SHALL write one word and increment a log2(BEATS)-bit beat counter.
REQ-019 After the BEATS-th beat, FSM SHALL go to DONE; bus_respcyc outside RESP SHALL NOT be acked or stored.
REQ-020 DONE: fill_valid=1 for exactly one cycle with fill_addr/fill_data valid, then IDLE.
REQ-021 miss_req outside IDLE SHALL be ignored (miss_ready=0).
REQ-022 Minimum latency: accept at cycle T, grant at T+1, reqack at T+2, beats T+3..T+10 -> fill_valid at T+11.
REQ-023 fill_data/fill_addr SHALL hold their values until the next DONE.

Reset
REQ-024 reset_n=0 at any edge SHALL force IDLE; miss_ready=1, busreq=0, busidle=1, bus_reqcyc=0, bus_req=0, fill_valid=0, fill_addr=0, fill_data=0, beat counter=0.
REQ-025 Reset mid-refill SHALL discard the partial line, drop busreq the same edge, and emit no fill_valid.

Configuration
REQ-026 Macro REFILL_CRITICAL_WORD_FIRST_EN defined: bus_req = miss_addr aligned to 8 B; beat k SHALL be stored in word (start_word + k) mod BEATS.
REQ-027 Macro undefined: bus_req = miss_addr aligned to line (64 B); beat k SHALL be stored in word k.
REQ-028 In both modes fill_addr SHALL be line-aligned.

Verification
REQ-029 Reset, then miss_addr=0x1000, grant next cycle, reqack immediate, beats 0..7 back-to-back -> bus_req=0x1000, fill_valid at T+11, fill_data word i = beat i.
REQ-030 Grant withheld 5 cycles -> busreq high, busidle=1 throughout ARB, REQ entered only after grant; bus_reqcyc held 3 cycles until reqack.
REQ-031 Beats with bus_respcyc gaps (alternate cycles) -> exactly 8 acks, correct words, single fill_valid pulse.
REQ-032 reset_n low after 4th beat -> IDLE next edge, busreq=0, no fill_valid; new miss then completes normally.
REQ-033 REFILL_CRITICAL_WORD_FIRST_EN, miss_addr=0x1028 -> bus_req=0x1028, beat 0 lands in word 5, beat 3 in word 0, fill_addr=0x1000.
REQ-034 miss_req asserted during RESP and stray bus_respcyc in IDLE -> both ignored, no ack, state unchanged.
